bm_sqrt: RTL and testbench

Iterative fixed-point square-root stage of the Box-Muller AWGN generator. Consumes the signed natural-log value `e` produced by the log stage and computes f = sqrt(-2·e), the radius term that feeds the sin/cos multiply stage. It computes one root bit per cycle and uses a valid/ready handshake on both sides.

---
 rtl/bm_sqrt_if.sv | 20 ++
 rtl/bm_sqrt.sv | 119 +++++++++++
 tb/tb_bm_sqrt.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bm_sqrt_if.sv
// Handshake bundle for the Box-Muller square-root stage: log-stage sample in, radius term out.
interface bm_sqrt_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [30:0] e_in;
   logic               out_valid;
   logic               out_ready;
   logic [19:0]        f;
   logic               clamp;

   modport master (
      output in_valid, e_in, out_ready,
      input  in_ready, out_valid, f, clamp
   );

   modport slave (
      input  in_valid, e_in, out_ready,
      output in_ready, out_valid, f, clamp
   );
endinterface

// File: rtl/bm_sqrt.sv
// Box-Muller radius stage: f = sqrt(-2*e) by restoring digit-by-digit square root, one bit per cycle.
// Define BM_SQRT_ROUND_EN to compute one extra root bit and round half-up to 16 fractional bits.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// CALC  | one root bit per edge, MSB first
// DONE  | out_valid high, holding f/clamp until out_ready
module bm_sqrt (
   input  logic     clk,
   input  logic     rst_n,
   bm_sqrt_if.slave sif
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

`ifdef BM_SQRT_ROUND_EN
   localparam int N = 21;
`else
   localparam int N = 20;
`endif
   localparam int RAD_W = 2 * N;
   localparam logic [4:0] LAST = 5'(N - 1);

   state_t           state;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [19:0]      f_q;
   logic             clamp_q;
   logic             clamp_int;
   logic [RAD_W-1:0] rad;
   logic [21:0]      rem;
   logic [N-1:0]     root;
   logic [4:0]       cnt;

   logic             is_pos;
   logic [31:0]      x;
   logic [23:0]      rem_sh;
   logic [24:0]      trial;
   logic [24:0]      rem_sel;
   logic [21:0]      rem_nxt;
   logic [N-1:0]     root_nxt;
   logic [19:0]      f_calc;
   logic             unused_bits;

   // Positive log values are impossible from a valid uniform sample; clamp them to zero.
   assign is_pos = !sif.e_in[30] && (sif.e_in != 31'sd0);
   assign x      = 32'd0 - {sif.e_in, 1'b0};

   assign rem_sh   = {rem, rad[RAD_W-1 -: 2]};
   assign trial    = {1'b0, rem_sh} - 25'({root, 2'b01});
   assign rem_sel  = trial[24] ? {1'b0, rem_sh} : trial;
   assign rem_nxt  = rem_sel[21:0];
   assign root_nxt = {root[N-2:0], ~trial[24]};
   // Remainder never exceeds 2*root, so the top bits of the wide trial are always zero.
   assign unused_bits = ^rem_sel[24:22];

`ifdef BM_SQRT_ROUND_EN
   logic [20:0] f_sum;
   assign f_sum  = {1'b0, root_nxt[20:1]} + 21'(root_nxt[0]);
   assign f_calc = f_sum[20] ? 20'hFFFFF : f_sum[19:0];
`else
   assign f_calc = root_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         f_q         <= '0;
         clamp_q     <= 1'b0;
         clamp_int   <= 1'b0;
         rad         <= '0;
         rem         <= '0;
         root        <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sif.in_valid) begin
                  rad        <= {(is_pos ? 32'd0 : x), {(RAD_W-32){1'b0}}};
                  rem        <= '0;
                  root       <= '0;
                  cnt        <= '0;
                  clamp_int  <= is_pos;
                  in_ready_q <= 1'b0;
                  state      <= CALC;
               end
            end
            CALC: begin
               rad  <= {rad[RAD_W-3:0], 2'b00};
               rem  <= rem_nxt;
               root <= root_nxt;
               cnt  <= cnt + 5'd1;
               if (cnt == LAST) begin
                  f_q         <= f_calc;
                  clamp_q     <= clamp_int;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (sif.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sif.in_ready  = in_ready_q;
   assign sif.out_valid = out_valid_q;
   assign sif.f         = f_q;
   assign sif.clamp     = clamp_q;

endmodule

// File: tb/tb_bm_sqrt.sv
// Directed-vector bench for bm_sqrt: table of exact/known roots, reset, backpressure and streaming.
module tb_bm_sqrt;

`ifdef BM_SQRT_ROUND_EN
   localparam int N = 21;
`else
   localparam int N = 20;
`endif

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   bm_sqrt_if sif ();

   bm_sqrt u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [30:0] e;
      logic [19:0]        f;
      logic               clamp;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = 64'd1 << 21;
      while (lo < hi) begin
         mid = (lo + hi + 1) >> 1;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   function automatic logic [19:0] ref_f(input logic signed [30:0] e);
      longint          ev;
      longint unsigned x, r;
      ev = e;
      if (ev > 0) return 20'd0;
      x = longint'(-2 * ev);
`ifdef BM_SQRT_ROUND_EN
      r = isqrt(x << 10);
      r = (r >> 1) + (r & 1);
      if (r > 64'hFFFFF) r = 64'hFFFFF;
`else
      r = isqrt(x << 8);
`endif
      return r[19:0];
   endfunction

   // Offers one sample from IDLE, waits for the result, consumes it; reports latency in edges after capture.
   task automatic run_one(input logic signed [30:0] e, output logic [19:0] f,
                          output logic clamp, output int lat);
      sif.in_valid = 1'b1;
      sif.e_in     = e;
      step();
      sif.in_valid = 1'b0;
      lat = 0;
      while (!sif.out_valid && lat < 40) begin
         step();
         lat++;
      end
      f     = sif.f;
      clamp = sif.clamp;
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
   endtask

   initial begin
      logic [19:0]        f_got;
      logic               c_got;
      int                 lat;
      logic signed [30:0] e_cur;
      logic [19:0]        exp_q[$];
      int                 last_cap, n_cap, n_out, cyc;
      logic               fire;

      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{31'sd0,           20'h00000, 1'b0};
      vecs[1] = '{-31'sd8388608,    20'h10000, 1'b0};
      vecs[2] = '{-31'sd33554432,   20'h20000, 1'b0};
      vecs[3] = '{-31'sd134217728,  20'h40000, 1'b0};
      vecs[4] = '{-31'sd1073741824, 20'hB504F, 1'b0};
      vecs[5] = '{31'sd1000,        20'h00000, 1'b1};
      vecs[6] = '{-31'sd8388608,    20'h10000, 1'b0};
`ifdef BM_SQRT_ROUND_EN
      vecs[7] = '{-31'sd1,          20'd23,    1'b0};
      vecs[8] = '{-31'sd16777216,   20'd92682, 1'b0};
`else
      vecs[7] = '{-31'sd1,          20'd22,    1'b0};
      vecs[8] = '{-31'sd16777216,   20'd92681, 1'b0};
`endif

      rst_n         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b0;
      sif.e_in      = '0;
      step();
      check("rst_in_ready", 64'(sif.in_ready), 64'd1);
      check("rst_out_valid", 64'(sif.out_valid), 64'd0);
      check("rst_f", 64'(sif.f), 64'd0);
      check("rst_clamp", 64'(sif.clamp), 64'd0);
      rst_n = 1'b1;
      step();

      // Reset in the middle of a calculation
      sif.in_valid = 1'b1;
      sif.e_in     = -31'sd8388608;
      step();
      sif.in_valid = 1'b0;
      check("cap_in_ready_low", 64'(sif.in_ready), 64'd0);
      repeat (5) step();
      rst_n = 1'b0;
      step();
      check("midrst_out_valid", 64'(sif.out_valid), 64'd0);
      check("midrst_f", 64'(sif.f), 64'd0);
      check("midrst_in_ready", 64'(sif.in_ready), 64'd1);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         run_one(vecs[i].e, f_got, c_got, lat);
         check($sformatf("vec%0d_f", i), 64'(f_got), 64'(vecs[i].f));
         check($sformatf("vec%0d_clamp", i), 64'(c_got), 64'(vecs[i].clamp));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
         check($sformatf("vec%0d_idle", i), 64'(sif.in_ready), 64'd1);
      end

      // Backpressure: hold DONE for 50 cycles with noisy upstream
      sif.in_valid = 1'b1;
      sif.e_in     = -31'sd33554432;
      step();
      lat = 0;
      while (!sif.out_valid && lat < 40) begin
         sif.in_valid = lat[0];
         sif.e_in     = 31'($urandom);
         step();
         lat++;
      end
      check("bp_latency", 64'(lat), 64'(N));
      for (int k = 0; k < 50; k++) begin
         sif.in_valid = 1'($urandom);
         sif.e_in     = 31'($urandom);
         step();
         check("bp_out_valid", 64'(sif.out_valid), 64'd1);
         check("bp_f", 64'(sif.f), 64'h20000);
         check("bp_in_ready", 64'(sif.in_ready), 64'd0);
      end
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      step();
      sif.out_ready = 1'b0;
      check("bp_release_out_valid", 64'(sif.out_valid), 64'd0);
      check("bp_release_in_ready", 64'(sif.in_ready), 64'd1);

      // Back-to-back streaming with random negative inputs
      n_cap    = 0;
      n_out    = 0;
      last_cap = -1;
      cyc      = 0;
      e_cur    = 31'(-int'($urandom_range(1, 32'h4000_0000)));
      sif.e_in      = e_cur;
      sif.in_valid  = 1'b1;
      sif.out_ready = 1'b1;
      while (n_out < 100 && cyc < 4000) begin
         fire = sif.in_valid && sif.in_ready;
         step();
         cyc++;
         if (fire) begin
            exp_q.push_back(ref_f(e_cur));
            if (last_cap >= 0) check("stream_interval", 64'(cyc - last_cap), 64'(N + 2));
            last_cap = cyc;
            n_cap++;
            if (n_cap < 100) begin
               e_cur    = 31'(-int'($urandom_range(1, 32'h4000_0000)));
               sif.e_in = e_cur;
            end else begin
               sif.in_valid = 1'b0;
            end
         end
         if (sif.out_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_spurious_out", 64'd1, 64'd0);
            end else begin
               check("stream_f", 64'(sif.f), 64'(exp_q.pop_front()));
               check("stream_clamp", 64'(sif.clamp), 64'd0);
            end
            n_out++;
         end
      end
      check("stream_count", 64'(n_out), 64'd100);
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
